// File: rtl/sn_to_bn.sv
// Stochastic-to-binary converter: counts the ones in a window of 2^BN_WIDTH
// valid stream bits and presents the saturated count as a binary value.
module sn_to_bn #(
  parameter int BN_WIDTH = 4
) (
  input  logic                i_clk_stb,
  input  logic                i_rst_n_stb,
  input  logic                i_start_stb,
  input  logic                i_stop_stb,
  input  logic                i_sn_bit,
  input  logic                i_sn_valid,
  output logic [BN_WIDTH-1:0] o_bn,
  output logic                o_bn_valid,
  output logic                o_busy
);

  localparam int CW = BN_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(2**BN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] ones_next;

  // Stream handshake: i_sn_bit is consumed on every rising edge in COUNT where
  // i_sn_valid is high; there is no backpressure, the source never waits.
  assign ones_next = ones_cnt + CW'(i_sn_bit);

  always_ff @(posedge i_clk_stb or negedge i_rst_n_stb) begin
    if (!i_rst_n_stb) begin
      state      <= IDLE;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      o_bn       <= '0;
      o_bn_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_bn_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE behaves like IDLE for start/stop, which allows back-to-back windows.
          if (i_start_stb && !i_stop_stb) begin
            state    <= COUNT;
            ones_cnt <= '0;
            bit_cnt  <= '0;
            o_busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        COUNT: begin
          if (i_stop_stb) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (i_sn_valid) begin
            bit_cnt  <= bit_cnt + 1'b1;
            ones_cnt <= ones_next;
            if (bit_cnt == LAST_IDX) begin
              state      <= DONE;
              o_busy     <= 1'b0;
              o_bn_valid <= 1'b1;
              o_bn       <= ones_next[BN_WIDTH] ? '1 : ones_next[BN_WIDTH-1:0];
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn_to_bn.sv
// Bench for sn_to_bn: directed scenarios plus random traffic, checked each
// cycle against a window/queue model of the converter.
module tb_sn_to_bn;

  localparam int W = 4;
  localparam int L = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         sn_bit;
  logic         sn_valid;
  logic [W-1:0] bn;
  logic         bn_valid;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int busy_cnt = 0;
  int pulse_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_bn;

  sn_to_bn #(.BN_WIDTH(W)) dut (
    .i_clk_stb  (clk),
    .i_rst_n_stb(rst_n),
    .i_start_stb(start),
    .i_stop_stb (stop),
    .i_sn_bit   (sn_bit),
    .i_sn_valid (sn_valid),
    .o_bn       (bn),
    .o_bn_valid (bn_valid),
    .o_busy     (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural model: a window is either open (collecting bits into a queue)
  // or not; when the queue reaches L bits the saturated sum becomes the result.
  bit           m_in_win;
  bit           m_pulse;
  logic [W-1:0] m_bn;
  int           m_bits[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_win = 1'b0;
      m_pulse  = 1'b0;
      m_bn     = '0;
      m_bits.delete();
      exp_q.delete();
    end else begin
      m_pulse = 1'b0;
      if (stop) begin
        m_in_win = 1'b0;
        m_bits.delete();
      end else if (m_in_win) begin
        if (sn_valid) m_bits.push_back(int'(sn_bit));
        if (m_bits.size() == L) begin
          int sum;
          sum = 0;
          foreach (m_bits[i]) sum += m_bits[i];
          if (sum > L - 1) sum = L - 1;
          m_bn     = W'(sum);
          m_pulse  = 1'b1;
          m_in_win = 1'b0;
          m_bits.delete();
          exp_q.push_back(m_bn);
        end
      end else if (start) begin
        m_in_win = 1'b1;
        m_bits.delete();
      end
    end
  end

  // Scoreboard / compare process, sampling 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      check("bn", int'(bn), int'(m_bn));
      check("bn_valid", int'(bn_valid), int'(m_pulse));
      check("busy", int'(busy), int'(m_in_win));
      if (busy) busy_cnt++;
      if (bn_valid) begin
        pulse_cnt++;
        pulse_q.push_back(cyc);
        last_bn = bn;
        check("exp_q_nonempty", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("pulse_value", int'(bn), int'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks: inputs change only on the falling edge
  task automatic drive(input bit s, input bit p, input bit v, input bit b);
    start    = s;
    stop     = p;
    sn_valid = v;
    sn_bit   = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int t0;
  int p0;
  logic [15:0] pat;

  initial begin
    start = 1'b0; stop = 1'b0; sn_valid = 1'b0; sn_bit = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_bn", int'(bn), 0);
    check("rst_bn_valid", int'(bn_valid), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // All ones saturate to 15; busy for exactly L cycles
    busy_cnt = 0; p0 = pulse_cnt;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < L; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    check("ones_bn", int'(last_bn), 15);
    check("ones_model_bn", int'(m_bn), 15);
    check("ones_pulses", pulse_cnt - p0, 1);
    check("ones_busy_cycles", busy_cnt, 16);

    // All zeros
    p0 = pulse_cnt;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < L; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    check("zeros_bn", int'(last_bn), 0);
    check("zeros_pulses", pulse_cnt - p0, 1);

    // Ten ones with five gap cycles carrying sn_bit=1
    pat = 16'b1011_0110_1101_0101;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    t0 = cyc;
    for (int i = 0; i < L; i++) begin
      drive(1'b0, 1'b0, 1'b1, pat[i]);
      if (i % 3 == 2 && i < 15) drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
    idle(3);
    check("gaps_bn", int'(last_bn), 10);
    check("gaps_model_bn", int'(m_bn), 10);
    check("gaps_latency", pulse_q[pulse_q.size() - 1] - t0, 21);

    // Stop wins over start mid-window; result stays 10
    p0 = pulse_cnt;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("stop_busy", int'(busy), 0);
    idle(20);
    check("stop_no_pulse", pulse_cnt - p0, 0);
    check("stop_bn_kept", int'(bn), 10);

    // Asynchronous reset mid-window, then a start-free stream
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_bn", int'(bn), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_bn_valid", int'(bn_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    for (int i = 0; i < L; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    check("post_rst_no_pulse", pulse_cnt - p0, 0);
    check("post_rst_busy", int'(busy), 0);

    // Start held high through DONE: back-to-back windows, second has 4 ones
    p0 = pulse_cnt;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < L; i++) drive(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < L; i++) drive(1'b1, 1'b0, 1'b1, i < 4);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("b2b_pulses", pulse_cnt - p0, 2);
    check("b2b_bn", int'(last_bn), 4);
    if (pulse_cnt - p0 == 2)
      check("b2b_spacing", pulse_q[pulse_q.size() - 1] - pulse_q[pulse_q.size() - 2], L + 1);

    // Random traffic
    p0 = pulse_cnt;
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    idle(4);
    check("random_pulses_seen", int'(pulse_cnt - p0 > 10), 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
